// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signal bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   reqValid;
    logic [8*NUM_REQ-1:0] reqData;
    logic [NUM_REQ-1:0]   reqReady;
    logic [IDW-1:0]       grantId;
    logic                 arbActive;
    logic [7:0]           txData;
    logic                 txDataValid;
    logic                 txBusy;
    logic                 timeoutErr;

    modport slave (
        input  reqValid, reqData, txBusy,
        output reqReady, grantId, arbActive, txData, txDataValid, timeoutErr
    );

    modport master (
        output reqValid, reqData, txBusy,
        input  reqReady, grantId, arbActive, txData, txDataValid, timeoutErr
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional macro UART_TX_ARB_PRIO0_EN gives requester 0 strict priority.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_arbiter_if.slave   bus
);
    localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic               arb_active_q, arb_active_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               timeout_err_q, timeout_err_d;

    logic               win_found_s;
    logic [IDW-1:0]     win_id_s;
    logic               upd_last_s;

    // Winner search: scan downward so the requester closest after last wins.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = '0;
        upd_last_s  = 1'b1;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.reqValid[(int'(last_q) + k) % NUM_REQ]) begin
                win_found_s = 1'b1;
                win_id_s    = IDW'((int'(last_q) + k) % NUM_REQ);
            end else begin
                win_found_s = win_found_s;
            end
        end
`ifdef UART_TX_ARB_PRIO0_EN
        // Requester 0 overrides the rotation and leaves the pointer untouched.
        if (bus.reqValid[0]) begin
            win_found_s = 1'b1;
            win_id_s    = '0;
            upd_last_s  = 1'b0;
        end else begin
            upd_last_s  = 1'b1;
        end
`endif
    end

    // Next-state and registered-output logic for the frame handshake.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        req_ready_d   = '0;
        grant_id_d    = grant_id_q;
        arb_active_d  = arb_active_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                // A busy transmitter (e.g. after a mid-frame reset) blocks new grants.
                if (!bus.txBusy && win_found_s) begin
                    req_ready_d[win_id_s] = 1'b1;
                    tx_data_d    = bus.reqData[{win_id_s, 3'b000} +: 8];
                    grant_id_d   = win_id_s;
                    last_d       = upd_last_s ? win_id_s : last_q;
                    tx_valid_d   = 1'b1;
                    arb_active_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = WAIT_BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (bus.txBusy) begin
                    tx_valid_d = 1'b0;
                    state_d    = WAIT_DONE;
                end else if (cnt_q == CNTW'(BUSY_TIMEOUT - 1)) begin
                    tx_valid_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    arb_active_d  = 1'b0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            WAIT_DONE: begin
                tx_valid_d = 1'b0;
                if (!bus.txBusy) begin
                    arb_active_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                tx_valid_d   = 1'b0;
                arb_active_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_q        <= IDW'(NUM_REQ - 1);
            cnt_q         <= '0;
            req_ready_q   <= '0;
            grant_id_q    <= '0;
            arb_active_q  <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            grant_id_q    <= grant_id_d;
            arb_active_q  <= arb_active_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.reqReady    = req_ready_q;
    assign bus.grantId     = grant_id_q;
    assign bus.arbActive   = arb_active_q;
    assign bus.txData      = tx_data_q;
    assign bus.txDataValid = tx_valid_q;
    assign bus.timeoutErr  = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small transmitter model that
// raises txBusy one cycle after txDataValid and records each byte sent.
module tb_uart_tx_arbiter;
    localparam int FRAME = 10;

    logic clk;
    logic rst_n;
    logic model_en;
    logic force_busy;
    int   busy_cnt;
    logic [7:0] line_q [0:31];
    int   line_n;
    int   n_vec;
    int   n_err;

    uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

    uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.txBusy = force_busy | (busy_cnt != 0);

    // Transmitter model: accept on txDataValid, stay busy FRAME cycles.
    always @(posedge clk) begin
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (model_en && bus.txDataValid) begin
            busy_cnt         <= FRAME;
            line_q[line_n[4:0]] <= bus.txData;
            line_n           <= line_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        @(negedge clk);
        while (bus.arbActive && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("idle_reached", {31'd0, bus.arbActive}, 32'd0);
    endtask

    task automatic wait_grant();
        int c;
        c = 0;
        @(negedge clk);
        while (bus.reqReady == 4'b0000 && c < 100) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        int c;
        int cnt;
        int ln;
        int exp_id;
        n_vec = 0; n_err = 0; ln = 0;
        busy_cnt = 0; line_n = 0;
        model_en = 1'b1; force_busy = 1'b0;
        bus.reqValid = 4'b0000;
        bus.reqData  = 32'h0000_0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_reqReady",    {28'd0, bus.reqReady}, 32'd0);
        chk("rst_grantId",     {30'd0, bus.grantId}, 32'd0);
        chk("rst_arbActive",   {31'd0, bus.arbActive}, 32'd0);
        chk("rst_txData",      {24'd0, bus.txData}, 32'd0);
        chk("rst_txDataValid", {31'd0, bus.txDataValid}, 32'd0);
        chk("rst_timeoutErr",  {31'd0, bus.timeoutErr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from requester 1
        bus.reqValid = 4'b0010;
        bus.reqData  = 32'h0000_A500;
        @(negedge clk);
        chk("single_ready",  {28'd0, bus.reqReady}, 32'h2);
        chk("single_gid",    {30'd0, bus.grantId}, 32'd1);
        chk("single_data",   {24'd0, bus.txData}, 32'hA5);
        chk("single_valid",  {31'd0, bus.txDataValid}, 32'd1);
        chk("single_active", {31'd0, bus.arbActive}, 32'd1);
        bus.reqValid = 4'b0000;
        bus.reqData  = 32'h0000_0000;
        @(negedge clk);
        chk("single_ready_pulse", {28'd0, bus.reqReady}, 32'd0);
        chk("single_busy_up",     {31'd0, bus.txBusy}, 32'd1);
        @(negedge clk);
        chk("single_valid_fall",  {31'd0, bus.txDataValid}, 32'd0);
        chk("single_data_held",   {24'd0, bus.txData}, 32'hA5);
        wait_idle();
        chk("single_busy_done",   {31'd0, bus.txBusy}, 32'd0);
        chk("single_line",        {24'd0, line_q[ln]}, 32'hA5);
        ln = ln + 1;

        // Fairness with all four requesters held (pointer reset to 3)
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.reqValid = 4'b1111;
        bus.reqData  = 32'h1312_1110;
        for (int g = 0; g < 8; g++) begin
            wait_grant();
`ifdef UART_TX_ARB_PRIO0_EN
            exp_id = 0;
`else
            exp_id = g % 4;
`endif
            chk("fair_ready", {28'd0, bus.reqReady}, 32'd1 << exp_id);
            chk("fair_gid",   {30'd0, bus.grantId}, exp_id);
            if (g == 7) bus.reqValid = 4'b0000;
        end
        wait_idle();
        for (int g = 0; g < 8; g++) begin
`ifdef UART_TX_ARB_PRIO0_EN
            exp_id = 0;
`else
            exp_id = g % 4;
`endif
            chk("fair_line", {24'd0, line_q[ln]}, 32'h10 + exp_id);
            ln = ln + 1;
        end

        // Busy timeout on requester 2 (pointer now 3)
        model_en = 1'b0;
        bus.reqValid = 4'b0100;
        bus.reqData  = 32'h4400_6600;
        @(negedge clk);
        chk("to_ready", {28'd0, bus.reqReady}, 32'h4);
        bus.reqValid = 4'b1001;
        cnt = 1; c = 0;
        @(negedge clk);
        while (bus.txDataValid && c < 40) begin
            cnt++; c++;
            @(negedge clk);
        end
        chk("to_valid_len", cnt, 32'd16);
        chk("to_err_pulse", {31'd0, bus.timeoutErr}, 32'd1);
        chk("to_active",    {31'd0, bus.arbActive}, 32'd0);
        @(negedge clk);
        chk("to_err_end",   {31'd0, bus.timeoutErr}, 32'd0);
`ifdef UART_TX_ARB_PRIO0_EN
        chk("to_next_grant", {28'd0, bus.reqReady}, 32'h1);
`else
        chk("to_next_grant", {28'd0, bus.reqReady}, 32'h8);
`endif
        model_en = 1'b1;
        bus.reqValid = 4'b0000;
        wait_idle();
`ifdef UART_TX_ARB_PRIO0_EN
        chk("to_line", {24'd0, line_q[ln]}, 32'h00);
`else
        chk("to_line", {24'd0, line_q[ln]}, 32'h44);
`endif
        ln = ln + 1;

        // Transmitter busy while idle blocks the grant
        force_busy = 1'b1;
        bus.reqValid = 4'b0001;
        bus.reqData  = 32'h0000_005A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busyidle_ready", {28'd0, bus.reqReady}, 32'd0);
            chk("busyidle_valid", {31'd0, bus.txDataValid}, 32'd0);
        end
        force_busy = 1'b0;
        @(negedge clk);
        chk("busyidle_grant", {28'd0, bus.reqReady}, 32'h1);
        chk("busyidle_vld",   {31'd0, bus.txDataValid}, 32'd1);
        bus.reqValid = 4'b0000;
        wait_idle();
        chk("busyidle_line", {24'd0, line_q[ln]}, 32'h5A);
        ln = ln + 1;

        // Reset during WAIT_DONE with the transmitter still sending
        bus.reqValid = 4'b0010;
        bus.reqData  = 32'h0077_C300;
        @(negedge clk);
        chk("mid_ready", {28'd0, bus.reqReady}, 32'h2);
        bus.reqValid = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("mid_in_frame", {30'd0, bus.arbActive, bus.txBusy}, 32'h3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_active", {31'd0, bus.arbActive}, 32'd0);
        chk("mid_rst_data",   {24'd0, bus.txData}, 32'd0);
        chk("mid_rst_valid",  {31'd0, bus.txDataValid}, 32'd0);
        chk("mid_rst_gid",    {30'd0, bus.grantId}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        @(negedge clk);
        chk("mid_busy_after", {31'd0, bus.txBusy}, 32'd1);
        while (bus.txBusy && c < 50) begin
            chk("mid_no_valid", {31'd0, bus.txDataValid}, 32'd0);
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        chk("mid_regrant_vld", {31'd0, bus.txDataValid}, 32'd1);
        chk("mid_regrant_rdy", {28'd0, bus.reqReady}, 32'h4);
        bus.reqValid = 4'b0000;
        wait_idle();
        chk("mid_line0", {24'd0, line_q[ln]}, 32'hC3);
        chk("mid_line1", {24'd0, line_q[ln+1]}, 32'h77);
        ln = ln + 2;

        // Back-to-back frames from requesters 0 and 1 (pointer at 2)
        bus.reqValid = 4'b0011;
        bus.reqData  = 32'h0000_2221;
        @(negedge clk);
        chk("b2b_first", {28'd0, bus.reqReady}, 32'h1);
        bus.reqValid = 4'b0010;
        c = 0;
        while (!bus.txBusy && c < 20) begin @(negedge clk); c++; end
        while (bus.txBusy && c < 60) begin @(negedge clk); c++; end
        @(negedge clk);
        chk("b2b_gap_valid", {31'd0, bus.txDataValid}, 32'd0);
        @(negedge clk);
        chk("b2b_second_vld", {31'd0, bus.txDataValid}, 32'd1);
        chk("b2b_second_rdy", {28'd0, bus.reqReady}, 32'h2);
        chk("b2b_second_gid", {30'd0, bus.grantId}, 32'd1);
        bus.reqValid = 4'b0000;
        wait_idle();
        chk("b2b_line0", {24'd0, line_q[ln]}, 32'h21);
        chk("b2b_line1", {24'd0, line_q[ln+1]}, 32'h22);
        ln = ln + 2;
        chk("line_count", line_n, ln);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-producing requesters using round-robin arbitration.
- Latches the granted byte and holds it stable on txData for the whole frame.
- Drives the transmitter's txDataValid/txBusy handshake and recovers if txBusy never rises.
- Sits between application logic (e.g. loopback echo, status reporter) and the UART TX serializer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 16, cycles to wait in WAIT_BUSY for txBusy to assert before aborting.

Ports:
- clk  input  1  system clock (27 MHz).
- rst_n  input  1  asynchronous active-low reset.
- reqValid  input  NUM_REQ  per-requester byte-valid; held until reqReady.
- reqData  input  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i].
- reqReady  output  NUM_REQ  one-cycle accept pulse, one-hot.
- grantId  output  $clog2(NUM_REQ)  index of the requester owning the current frame.
- arbActive  output  1  high from accept until frame done or abort.
- txData  output  8  byte to the transmitter; stable from accept until return to IDLE.
- txDataValid  output  1  transmit request to the transmitter.
- txBusy  input  1  transmitter busy flag.
- timeoutErr  output  1  one-cycle pulse on BUSY_TIMEOUT abort.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: reqReady=0, grantId=0, arbActive=0, txData=0, txDataValid=0, timeoutErr=0.
  - Internal: state=IDLE, round-robin pointer last=NUM_REQ-1, timeout counter=0.
  - Release is synchronous to clk.
- IDLE:
  - Grants only when txBusy==0 and any reqValid is set. This covers a transmitter still finishing a frame after a mid-frame reset.
  - Winner: first set reqValid scanning from last+1 upward with wrap-around.
  - On grant, all registered and effective next cycle: reqReady[w]=1 for exactly one cycle; txData=reqData[w]; grantId=w; last=w; txDataValid=1; arbActive=1; state=WAIT_BUSY; counter=0.
- WAIT_BUSY:
  - txDataValid held 1.
  - If txBusy==1: txDataValid=0, state=WAIT_DONE.
  - Else if counter==BUSY_TIMEOUT-1: txDataValid=0, timeoutErr pulses 1 cycle, arbActive=0, state=IDLE.
  - Else counter+1.
- WAIT_DONE:
  - txDataValid=0.
  - When txBusy==0: arbActive=0, state=IDLE.
  - No upper time bound; the frame is about 10*234 cycles.
- Latency:
  - reqValid seen in IDLE at cycle N gives reqReady/txDataValid high at N+1.
  - With the standard transmitter, txBusy rises at N+2 and txDataValid falls at N+3.
  - Minimum idle gap between frames: 1 cycle (IDLE re-evaluation).
- Data rules:
  - txData never changes outside IDLE.
  - reqData of non-granted requesters is ignored.
  - A requester dropping reqValid before accept is legal and is simply not granted.
- Simultaneous requests: round robin. After grant to i, requester i has lowest priority next round.
- Timeout abort: the byte is consumed (reqReady already pulsed) and is not retried.
- Invariants:
  - txDataValid never asserts while txBusy==1 in IDLE.
  - reqReady is always one-hot or zero.

Optional Feature:
- Macro: UART_TX_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority. If reqValid[0]=1 in IDLE it wins regardless of pointer, and last is not updated. Remaining requesters use round robin among themselves.
- Undefined: pure round robin across all NUM_REQ.

Test Plan:
- Single request: reqValid=4'b0010, reqData[15:8]=8'hA5 → reqReady=4'b0010 for 1 cycle, grantId=1, txData=8'hA5 held through frame, serial line carries A5 once, arbActive falls after txBusy falls.
- Fairness: all four reqValid held continuously with data 8'h10..8'h13 → grant order 0,1,2,3,0,... and bytes 10,11,12,13 appear on line in that order (with UART_TX_ARB_PRIO0_EN: grant order 0,0,0,... while req0 held).
- Timeout: txBusy tied 0, reqValid[2]=1 → txDataValid high exactly 16 cycles, then timeoutErr pulse, state IDLE, next grant goes to requester 3 if pending.
- Busy at idle: txBusy forced 1, reqValid[0]=1 → no reqReady, txDataValid stays 0 until txBusy=0, then grant 1 cycle later.
- Mid-frame reset: assert rst_n=0 during WAIT_DONE → all outputs 0 immediately; after release with txBusy still 1, no new txDataValid until transmitter finishes.
- Back-to-back: req0 then req1 both pending → second txDataValid asserts 2 cycles after txBusy falls from first frame, with no dropped or duplicated byte.
